aes_round_iter: RTL and testbench

AES_ROUND_ITER -- requirements
Module: aes_round_iter

---
 rtl/aes_round_iter_if.sv | 25 ++
 rtl/aes_round_iter.sv | 133 +++++++++++++
 tb/tb_aes_round_iter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_iter_if.sv
// Block-facing bundle for the iterative AES-128/192/256 encrypt core: plaintext in,
// round-key request/response, ciphertext out.
interface aes_round_iter_if #(
  parameter int KIDX_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_data;
  logic [KIDX_W-1:0] rk_idx;
  logic [127:0]      rk;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_round_iter.sv
// Iterative AES encryptor: two cycles per round (registered S-box lookup, then
// ShiftRows/MixColumns/AddRoundKey); ciphertext held in DONE until out_ready.
module aes_round_iter #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input logic            clk,
  input logic            rst,
  aes_round_iter_if.slave bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $fatal(1, "aes_round_iter: NR must be 10, 12 or 14");
  end
  if (KIDX_W < $clog2(NR + 1)) begin : g_bad_kidx
    $fatal(1, "aes_round_iter: KIDX_W too narrow for NR");
  end

  localparam logic [KIDX_W-1:0] NR_K  = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] ONE_K = KIDX_W'(1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {S_IDLE, S_ARK, S_LOOKUP, S_MIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [KIDX_W-1:0] r_q, r_d;
  logic [127:0]      st_q, st_d;
  logic [127:0]      sb_q;
  logic              init_q;
  logic [127:0]      sr_v, mc_v, round_v;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      st_q    <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      st_q    <= st_d;
      init_q  <= 1'b1;
    end
  end

  // Synchronous S-box ROM, read only during the first cycle of each round.
  always_ff @(posedge clk) begin
    if (state_q == S_LOOKUP) begin
      for (int k = 0; k < 16; k++) sb_q[127-8*k -: 8] <= sbox(st_q[127-8*k -: 8]);
    end
  end

  always_comb begin
    sr_v = '0;
    mc_v = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_v[127-8*(4*c+r) -: 8] = sb_q[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) mc_v[127-32*c -: 32] = mix_col(sr_v[127-32*c -: 32]);
    round_v = ((r_q == NR_K) ? sr_v : mc_v) ^ bus.rk;
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    st_d    = st_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && init_q) begin
          st_d    = bus.in_data ^ bus.rk;
          r_d     = ONE_K;
          state_d = S_LOOKUP;
        end
      end
      S_ARK:    state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_MIX;
      S_MIX: begin
        st_d = round_v;
        if (r_q == NR_K) begin
          state_d = S_DONE;
        end else begin
          r_d     = r_q + ONE_K;
          state_d = S_LOOKUP;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          r_d     = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE) && init_q;
    bus.busy      = (state_q != S_IDLE);
    bus.rk_idx    = (state_q == S_MIX) ? r_q : '0;
    bus.out_valid = (state_q == S_DONE);
    bus.out_data  = (state_q == S_DONE) ? st_q : '0;
  end

endmodule

// File: tb/tb_aes_round_iter.sv
// Runs NR=10/12/14 instances side by side on shared stimulus against a
// cycle-level AES reference with its own key schedule and computed S-box.
module tb_aes_round_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, out_ready;
  logic [127:0] in_data, noise;

  aes_round_iter_if #(.KIDX_W(4)) bus0 ();
  aes_round_iter_if #(.KIDX_W(4)) bus1 ();
  aes_round_iter_if #(.KIDX_W(4)) bus2 ();

  aes_round_iter #(.NR(10), .KIDX_W(4)) u_dut10 (.clk(clk), .rst(rst), .bus(bus0));
  aes_round_iter #(.NR(12), .KIDX_W(4)) u_dut12 (.clk(clk), .rst(rst), .bus(bus1));
  aes_round_iter #(.NR(14), .KIDX_W(4)) u_dut14 (.clk(clk), .rst(rst), .bus(bus2));

  int           nrs [3];
  int           lat [3];
  logic [127:0] fips[3];
  logic [127:0] rks [3][15];
  logic [7:0]   sb_tab[256];
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic         i_rdy[3], o_vld[3], o_busy[3];
  logic [3:0]   o_idx[3];
  logic [127:0] o_dat[3], rk_drv[3];

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;
  assign bus0.in_data  = in_data;   assign bus1.in_data  = in_data;   assign bus2.in_data  = in_data;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;
  assign bus0.rk = rk_drv[0];       assign bus1.rk = rk_drv[1];       assign bus2.rk = rk_drv[2];
  assign i_rdy[0] = bus0.in_ready;  assign i_rdy[1] = bus1.in_ready;  assign i_rdy[2] = bus2.in_ready;
  assign o_vld[0] = bus0.out_valid; assign o_vld[1] = bus1.out_valid; assign o_vld[2] = bus2.out_valid;
  assign o_busy[0] = bus0.busy;     assign o_busy[1] = bus1.busy;     assign o_busy[2] = bus2.busy;
  assign o_idx[0] = bus0.rk_idx;    assign o_idx[1] = bus1.rk_idx;    assign o_idx[2] = bus2.rk_idx;
  assign o_dat[0] = bus0.out_data;  assign o_dat[1] = bus1.out_data;  assign o_dat[2] = bus2.out_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h", nm, inst, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    logic [31:0] o;
    for (int b = 0; b < 4; b++) o[31-8*b -: 8] = sb_tab[w[31-8*b -: 8]];
    return o;
  endfunction

  task automatic build_keys();
    logic [31:0] w[60];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    int nk, nw;
    for (int i = 0; i < 3; i++) begin
      nk = nrs[i] - 6;
      nw = 4 * (nrs[i] + 1);
      rcon = 8'h01;
      for (int k = 0; k < 60; k++) w[k] = '0;
      for (int k = 0; k < nk; k++) w[k] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      for (int k = nk; k < nw; k++) begin
        tmp = w[k-1];
        if (k % nk == 0) begin
          tmp  = subword({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end else if (nk > 6 && k % nk == 4) begin
          tmp = subword(tmp);
        end
        w[k] = w[k-nk] ^ tmp;
      end
      for (int j = 0; j < 15; j++)
        rks[i][j] = (j <= nrs[i]) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : rnd128();
    end
  endtask

  function automatic logic [127:0] aes_enc(input int inst, input logic [127:0] pt);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a[4];
    logic [127:0] v;
    v = pt ^ rks[inst][0];
    for (int rnd = 1; rnd <= nrs[inst]; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sb_tab[v[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd < nrs[inst]) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = t[4*c+r];
          t[4*c]   = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
          t[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
          t[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
          t[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
        end
      end
      for (int k = 0; k < 16; k++) v[127-8*k -: 8] = t[k];
      v = v ^ rks[inst][rnd];
    end
    return v;
  endfunction

  // Reference timeline: phase 0 idle, 1 busy (m_cnt = cycles since acceptance), 2 done.
  int           m_ph [3];
  int           m_cnt[3];
  logic [127:0] m_exp[3];
  logic         m_init;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_init <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_ph[i]  <= 0;
        m_cnt[i] <= 0;
      end
    end else begin
      m_init <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        case (m_ph[i])
          0: if (in_valid && m_init) begin
               m_ph[i]  <= 1;
               m_cnt[i] <= 1;
               m_exp[i] <= aes_enc(i, in_data);
             end
          1: if (m_cnt[i] == 2 * nrs[i]) m_ph[i] <= 2;
             else m_cnt[i] <= m_cnt[i] + 1;
          default: if (out_ready) m_ph[i] <= 0;
        endcase
      end
    end
  end

  always @(posedge clk) noise <= rnd128();

  // The key store answers rk_idx, but feeds garbage on cycles where no key may be consumed.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rk_drv[i] = noise;
      if (!(m_ph[i] == 2 || (m_ph[i] == 1 && m_cnt[i] % 2 == 1)) && int'(o_idx[i]) <= nrs[i])
        rk_drv[i] = rks[i][o_idx[i]];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        chk("rst_in_ready",  i, 128'(i_rdy[i]),  128'(0));
        chk("rst_out_valid", i, 128'(o_vld[i]),  128'(0));
        chk("rst_busy",      i, 128'(o_busy[i]), 128'(0));
        chk("rst_rk_idx",    i, 128'(o_idx[i]),  128'(0));
        chk("rst_out_data",  i, o_dat[i],        128'(0));
      end else begin
        chk("in_ready",  i, 128'(i_rdy[i]),  128'(m_ph[i] == 0 && m_init));
        chk("out_valid", i, 128'(o_vld[i]),  128'(m_ph[i] == 2));
        chk("busy",      i, 128'(o_busy[i]), 128'(m_ph[i] != 0));
        chk("rk_idx",    i, 128'(o_idx[i]),
            128'((m_ph[i] == 1 && m_cnt[i] % 2 == 0) ? m_cnt[i] / 2 : 0));
        if (m_ph[i] == 2) chk("out_data", i, o_dat[i], m_exp[i]);
      end
    end
  end

  // Called just after a rising edge with every instance idle and ready.
  task automatic fips_run();
    int           first[3];
    logic [127:0] dat[3];
    for (int i = 0; i < 3; i++) begin
      first[i] = 0;
      dat[i]   = '0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = PT;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom % 2);
      in_data  = rnd128();
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (o_vld[i] && first[i] == 0) begin
          first[i] = cyc;
          dat[i]   = o_dat[i];
        end
    end
    for (int i = 0; i < 3; i++) begin
      chk("latency", i, 128'(first[i]), 128'(lat[i]));
      chk("fips_ct", i, dat[i], fips[i]);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("release_idle", i, 128'(o_busy[i]), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    nrs  = '{10, 12, 14};
    lat  = '{21, 25, 29};
    fips = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
             128'hdda97ca4864cdfe06eaf70a0ec0d7191,
             128'h8ea2b7ca516745bfeafc49904b496089};
    build_sbox();
    build_keys();
    chk("model_sbox00", 0, 128'(sb_tab[8'h00]), 128'h63);
    chk("model_sbox53", 0, 128'(sb_tab[8'h53]), 128'hed);
    for (int i = 0; i < 3; i++) chk("model_fips", i, aes_enc(i, PT), fips[i]);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    fips_run();

    // Abort mid-block at round 5 of the NR=10 instance.
    in_valid = 1'b1;
    in_data  = rnd128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    fips_run();

    // Back-to-back with in_valid held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (80) begin
      @(posedge clk); #1;
      in_data = rnd128();
    end
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    repeat (3000) begin
      @(posedge clk); #1;
      rst       = ($urandom % 600 == 0);
      in_valid  = 1'($urandom % 2);
      in_data   = rnd128();
      out_ready = ($urandom % 3 != 0);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
